// File: rtl/bitcell_array_ctrl.sv
// bitcell_array_ctrl: sequences word read/write requests onto a NAND-latch bitcell array,
// framing every sel pulse with a setup and a hold cycle so r_w/in never move under sel.
module bitcell_array_ctrl #(
  parameter int WORDS        = 4,
  parameter int WIDTH        = 8,
  parameter int ADDR_W       = 2,
  parameter int WRITE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WIDTH-1:0]  req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WIDTH-1:0]  rsp_rdata,
  output logic              rsp_err,
  output logic              cell_r_w,
  output logic [WORDS-1:0]  cell_sel,
  output logic [WIDTH-1:0]  cell_in,
  input  logic [WIDTH-1:0]  cell_out
);
  localparam int CW = $clog2(WRITE_CYCLES) + 1;
  typedef enum logic [2:0] {IDLE, SETUP, ACCESS, HOLD, RESP} state_t;
  state_t r_state, w_next;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [WIDTH-1:0]  r_wdata;
  logic [CW-1:0]     r_cnt;
  logic              w_accept, w_we, w_legal, w_drive, w_r_w, w_valid, w_err;
  logic [ADDR_W-1:0] w_addr;
  logic [WIDTH-1:0]  w_wdata, w_in, w_rdata;
  logic [WORDS-1:0]  w_sel;
  assign req_ready = rst_n && r_state == IDLE;
  assign w_accept  = req_valid && req_ready;
  // outputs are registered from the next state, so the accept edge must see the incoming request
  assign w_we      = w_accept ? req_we : r_we;
  assign w_addr    = w_accept ? req_addr : r_addr;
  assign w_wdata   = w_accept ? req_wdata : r_wdata;
  assign w_legal   = int'(w_addr) < WORDS;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_we    <= req_we;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
      end
      r_cnt <= r_state == ACCESS ? r_cnt - 1'b1 : (r_we ? CW'(WRITE_CYCLES - 1) : '0);
    end
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = SETUP;
      SETUP:   w_next = ACCESS;
      ACCESS:  if (r_cnt == '0) w_next = HOLD;
      HOLD:    w_next = RESP;
      RESP:    if (rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  always_comb begin
    w_drive = w_next inside {SETUP, ACCESS, HOLD};
    w_r_w   = w_drive && w_we;
    w_in    = w_r_w ? w_wdata : '0;
    w_sel   = (w_next == ACCESS && w_legal) ? WORDS'(1) << w_addr : '0;
    w_valid = w_next == RESP;
    w_err   = w_valid && !w_legal;
    w_rdata = (r_state == ACCESS && w_next == HOLD && !r_we && w_legal) ? cell_out :
              (w_valid ? rsp_rdata : '0);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cell_r_w  <= 1'b0;
      cell_sel  <= '0;
      cell_in   <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      cell_r_w  <= w_r_w;
      cell_sel  <= w_sel;
      cell_in   <= w_in;
      rsp_valid <= w_valid;
      rsp_err   <= w_err;
      rsp_rdata <= w_rdata;
    end
  end
endmodule

// File: tb/tb_bitcell_array_ctrl.sv
// tb_bitcell_array_ctrl: randomized bench for bitcell_array_ctrl with a behavioural array and a
// word-level memory model; a free-running monitor guards one-hot sel and r_w/in stability.
module tb_bitcell_array_ctrl;
  localparam int WORDS = 3, WIDTH = 8, ADDR_W = 2, WC = 2;
  logic clk = 0, rst_n = 0, req_valid = 0, req_we = 0, rsp_ready = 0;
  logic req_ready, rsp_valid, rsp_err, cell_r_w;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [WIDTH-1:0]  req_wdata = '0, rsp_rdata, cell_in, cell_out;
  logic [WORDS-1:0]  cell_sel;
  logic [WIDTH-1:0]  cells [WORDS] = '{default: '0};
  logic [WIDTH-1:0]  exp_mem [WORDS] = '{default: '0};
  int checks = 0, errors = 0;
  int obs_lat, obs_nsel;
  logic [WORDS-1:0] obs_selor, prev_sel = '0;
  logic obs_sel_rw, obs_err, obs_pre_rw, obs_post_rw, prev_rw = 0;
  logic [WIDTH-1:0] obs_rd, obs_pre_in, obs_post_in, prev_in = '0;

  always #5 clk = ~clk;

  bitcell_array_ctrl #(.WORDS(WORDS), .WIDTH(WIDTH), .ADDR_W(ADDR_W), .WRITE_CYCLES(WC)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .cell_r_w(cell_r_w), .cell_sel(cell_sel),
    .cell_in(cell_in), .cell_out(cell_out));

  // behavioural bitcell array
  always @(posedge clk)
    for (int r = 0; r < WORDS; r++) if (cell_r_w && cell_sel[r]) cells[r] <= cell_in;
  always_comb begin
    cell_out = '0;
    for (int r = 0; r < WORDS; r++) if (cell_sel[r]) cell_out = cell_out | cells[r];
  end

  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if ($countones(cell_sel) > 1 ||
          ((cell_sel != 0 || prev_sel != 0) && (cell_r_w !== prev_rw || cell_in !== prev_in))) begin
        errors++;
        $display("FAIL sel_guard sel=%b r_w=%b in=%h, previous sel=%b r_w=%b in=%h",
                 cell_sel, cell_r_w, cell_in, prev_sel, prev_rw, prev_in);
      end
    end
    prev_sel = cell_sel; prev_rw = cell_r_w; prev_in = cell_in;
  end

  task automatic xact(input bit we, input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] d, input bit rr);
    int w;
    bit post;
    logic lrw;
    logic [WIDTH-1:0] lin;
    @(negedge clk);
    req_valid = 1; req_we = we; req_addr = a; req_wdata = d; rsp_ready = rr;
    w = 0;
    while (!req_ready && w < 20) begin @(negedge clk); w++; end
    checks++;
    if (!req_ready) begin errors++; $display("FAIL accept_timeout req_ready=%b required 1", req_ready); end
    @(posedge clk); #1 req_valid = 0;
    @(negedge clk);
    obs_lat = 0; obs_nsel = 0; obs_selor = '0; obs_sel_rw = 0; post = 0;
    obs_pre_rw = 0; obs_pre_in = '0; obs_post_rw = 0; obs_post_in = '0;
    lrw = cell_r_w; lin = cell_in;
    while (!rsp_valid && obs_lat < 40) begin
      @(negedge clk); obs_lat++;
      if (cell_sel != 0) begin
        if (obs_nsel == 0) begin obs_pre_rw = lrw; obs_pre_in = lin; end
        obs_nsel++; obs_selor |= cell_sel; obs_sel_rw |= cell_r_w;
      end else if (obs_nsel != 0 && !post) begin
        post = 1; obs_post_rw = cell_r_w; obs_post_in = cell_in;
      end
      lrw = cell_r_w; lin = cell_in;
    end
    checks++;
    if (!rsp_valid) begin errors++; $display("FAIL rsp_timeout rsp_valid=%b required 1", rsp_valid); end
    obs_rd = rsp_rdata; obs_err = rsp_err;
    if (rr) @(posedge clk);
  endtask

  task automatic test_reset();
    int w;
    rst_n = 0;
    repeat (2) @(negedge clk);
    checks++; if (req_ready !== 0) begin errors++; $display("FAIL rst_ready got %b want 0", req_ready); end
    checks++; if (rsp_valid !== 0) begin errors++; $display("FAIL rst_valid got %b want 0", rsp_valid); end
    checks++; if (cell_sel !== 0 || cell_r_w !== 0 || cell_in !== 0)
      begin errors++; $display("FAIL rst_cell got sel=%b r_w=%b in=%h want 0", cell_sel, cell_r_w, cell_in); end
    rst_n = 1;
    @(negedge clk);
    checks++; if (req_ready !== 1) begin errors++; $display("FAIL rel_ready got %b want 1", req_ready); end
    req_valid = 1; req_we = 1; req_addr = 1; req_wdata = 8'h3C; rsp_ready = 1;
    @(posedge clk); #1 req_valid = 0;
    w = 0;
    while (cell_sel == 0 && w < 10) begin @(posedge clk); #1 w++; end
    checks++; if (cell_sel !== 3'b010) begin errors++; $display("FAIL abort_sel_before got %b want 010", cell_sel); end
    #2 rst_n = 0;
    #1;
    checks++; if (cell_sel !== 0) begin errors++; $display("FAIL abort_sel got %b want 0", cell_sel); end
    checks++; if (rsp_valid !== 0) begin errors++; $display("FAIL abort_valid got %b want 0", rsp_valid); end
    checks++; if (req_ready !== 0) begin errors++; $display("FAIL abort_ready got %b want 0", req_ready); end
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    checks++; if (req_ready !== 1 || cell_sel !== 0)
      begin errors++; $display("FAIL abort_release got ready=%b sel=%b want 1/000", req_ready, cell_sel); end
  endtask

  task automatic test_write();
    xact(1, 2, 8'hA5, 1);
    exp_mem[2] = 8'hA5;
    checks++; if (obs_lat != WC + 2) begin errors++; $display("FAIL wr_latency got %0d want %0d", obs_lat, WC + 2); end
    checks++; if (obs_nsel != WC) begin errors++; $display("FAIL wr_sel_cycles got %0d want %0d", obs_nsel, WC); end
    checks++; if (obs_selor !== 3'b100) begin errors++; $display("FAIL wr_sel got %b want 100", obs_selor); end
    checks++; if (obs_pre_rw !== 1 || obs_pre_in !== 8'hA5)
      begin errors++; $display("FAIL wr_setup got r_w=%b in=%h want 1/a5", obs_pre_rw, obs_pre_in); end
    checks++; if (obs_post_rw !== 1 || obs_post_in !== 8'hA5)
      begin errors++; $display("FAIL wr_hold got r_w=%b in=%h want 1/a5", obs_post_rw, obs_post_in); end
    checks++; if (obs_err !== 0 || obs_rd !== 0)
      begin errors++; $display("FAIL wr_rsp got err=%b rdata=%h want 0/00", obs_err, obs_rd); end
  endtask

  task automatic test_read();
    xact(0, 2, 8'($urandom), 1);
    checks++; if (obs_lat != 3) begin errors++; $display("FAIL rd_latency got %0d want 3", obs_lat); end
    checks++; if (obs_nsel != 1 || obs_selor !== 3'b100 || obs_sel_rw !== 0)
      begin errors++; $display("FAIL rd_sel got n=%0d sel=%b r_w=%b want 1/100/0", obs_nsel, obs_selor, obs_sel_rw); end
    checks++; if (obs_rd !== exp_mem[2] || obs_err !== 0)
      begin errors++; $display("FAIL rd_data got %h err=%b want %h/0", obs_rd, obs_err, exp_mem[2]); end
  endtask

  task automatic test_backpressure();
    logic [ADDR_W-1:0] a;
    a = ($urandom % 2) ? 2'd2 : 2'd0;
    xact(0, a, '0, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (rsp_valid !== 1 || rsp_rdata !== exp_mem[a] || req_ready !== 0)
        begin errors++; $display("FAIL bp_hold got valid=%b rdata=%h ready=%b want 1/%h/0", rsp_valid, rsp_rdata, req_ready, exp_mem[a]); end
    end
    rsp_ready = 1;
    @(negedge clk);
    checks++; if (req_ready !== 1 || rsp_valid !== 0)
      begin errors++; $display("FAIL bp_release got ready=%b valid=%b want 1/0", req_ready, rsp_valid); end
  endtask

  task automatic test_illegal();
    for (int i = 0; i < 2; i++) begin
      xact(i[0], 2'd3, 8'($urandom), 1);
      checks++; if (obs_lat != (i[0] ? WC + 2 : 3))
        begin errors++; $display("FAIL ill_latency got %0d want %0d", obs_lat, i[0] ? WC + 2 : 3); end
      checks++; if (obs_selor !== 0) begin errors++; $display("FAIL ill_sel got %b want 000", obs_selor); end
      checks++; if (obs_err !== 1 || obs_rd !== 0)
        begin errors++; $display("FAIL ill_rsp got err=%b rdata=%h want 1/00", obs_err, obs_rd); end
    end
  endtask

  task automatic test_back_to_back();
    int last;
    last = -1;
    @(negedge clk);
    req_valid = 1; req_we = 0; req_addr = 2'($urandom_range(WORDS - 1, 0)); rsp_ready = 1;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (req_ready) begin
        if (last >= 0) begin
          checks++; if (c - last != 5) begin errors++; $display("FAIL b2b_spacing got %0d want 5", c - last); end
        end
        last = c;
      end
    end
    req_valid = 0;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_rows();
    logic [WIDTH-1:0] d;
    logic [ADDR_W-1:0] a;
    bit we, legal;
    for (int r = 0; r < WORDS; r++) begin
      d = 8'($urandom); xact(1, 2'(r), d, 1); exp_mem[r] = d;
    end
    xact(1, 0, 8'h00, 1); exp_mem[0] = 8'h00;
    xact(1, 0, 8'hFF, 1); exp_mem[0] = 8'hFF;
    for (int r = 0; r < WORDS; r++) begin
      xact(0, 2'(r), '0, 1);
      checks++; if (obs_rd !== exp_mem[r] || obs_err !== 0)
        begin errors++; $display("FAIL row_read row %0d got %h want %h", r, obs_rd, exp_mem[r]); end
    end
    for (int i = 0; i < 24; i++) begin
      we = $urandom % 2; a = 2'($urandom_range(3, 0)); d = 8'($urandom);
      legal = int'(a) < WORDS;
      xact(we, a, d, 1);
      checks++; if (obs_lat != (we ? WC + 2 : 3) || obs_nsel != (legal ? (we ? WC : 1) : 0))
        begin errors++; $display("FAIL rnd_timing got lat=%0d nsel=%0d we=%b addr=%0d", obs_lat, obs_nsel, we, a); end
      checks++; if (obs_err !== !legal || obs_rd !== ((legal && !we) ? exp_mem[a] : 8'h00))
        begin errors++; $display("FAIL rnd_rsp got err=%b rdata=%h we=%b addr=%0d want err=%b", obs_err, obs_rd, we, a, !legal); end
      if (legal && we) exp_mem[a] = d;
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_backpressure();
    test_illegal();
    test_back_to_back();
    test_rows();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
